alu_ctrl: RTL and testbench
===========================

Name: alu_ctrl

Overview:
Packet sequencer between the UART byte streams and the combinational ALU. It parses command packets from the RX byte stream, feeds 32-bit operands to the ALU one at a time with a running accumulator, and serialises results to the TX byte stream. It is the only driver of the ALU opcode and operand inputs.

Parameters:
ALU_LATENCY, 1, cycles from alu_start_o pulse to alu_data_i being valid (1..4)
TIMEOUT_CYCLES, 1_000_000, idle cycles mid-packet before the parser aborts to IDLE (>=16)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_data_i  in  8  received byte
rx_valid_i  in  1  rx_data_i valid
rx_ready_o  out  1  byte accepted when rx_valid_i & rx_ready_o
tx_data_o  out  8  byte to transmit
tx_valid_o  out  1  tx_data_o valid; held with stable data until tx_ready_i
tx_ready_i  in  1  transmitter accepts byte
alu_opcode_o  out  8  opcode to ALU (0xEC echo, 0xAD add, 0xAC mul, 0xD1 div)
alu_start_o  out  1  one-cycle pulse starting an ALU evaluation
alu_data1_o  out  33  operand 1 (accumulator / dividend), bit 32 always 0
alu_data2_o  out  33  operand 2 (new word / divisor), bit 32 always 0
alu_data_i  in  33  ALU result; bit 32 ignored
busy_o  out  1  high in every state except IDLE
err_o  out  1  one-cycle pulse: unknown opcode, divide-by-zero, short div packet or timeout

Behaviour:
- Reset (rst low, async): state IDLE; rx_ready_o=1, tx_valid_o=0, alu_start_o=0, alu_opcode_o=0, alu_data1_o=0, alu_data2_o=0, busy_o=0, err_o=0; accumulator, counters and timeout cleared. Reset mid-packet or mid-transmit discards everything; no partial response follows.
- Packet: byte0 opcode, byte1 reserved (ignored), byte2 len[7:0], byte3 len[15:8]; len = total bytes including 4-byte header. len<4 treated as 4. Payload = len-4 bytes; operands 32-bit little-endian.
- States: IDLE -> HDR (bytes 1..3) -> PAYLOAD -> EXEC -> PAYLOAD ... -> RESP -> IDLE; ECHO_TX and DRAIN as side paths.
- IDLE: first accepted byte latched as opcode, go HDR. HDR end: payload=0 -> RESP (arith) or IDLE (echo/unknown); unknown opcode -> pulse err_o, DRAIN.
- Echo 0xEC: each payload byte accepted, rx_ready_o drops, byte presented on TX (ECHO_TX); after handshake rx_ready_o returns. Max 1 byte per 2 cycles. No ALU use.
- Add/Mul: accumulator init 0 (add) / 1 (mul) at header end. After every 4th payload byte: EXEC drives data1=acc, data2=word, opcode, pulses alu_start_o; rx_ready_o=0; after ALU_LATENCY cycles acc<=alu_data_i[31:0] (mod 2^32 wrap), back to PAYLOAD. Trailing 1-3 bytes accepted and ignored. After last byte, RESP sends acc as 4 bytes LE.
- Div 0xD1: word0 dividend, word1 divisor, further words ignored. Divisor 0 -> no ALU start, result 0xFFFF_FFFF, err_o pulse. Fewer than 2 words -> result 0xFFFF_FFFF, err_o pulse. Response 4 bytes LE.
- DRAIN: accepts and discards remaining payload bytes, then IDLE.
- RESP: rx_ready_o=0; tx_valid_o high with byte held until tx_ready_i; byte n+1 presented the cycle after handshake n.
- Timeout: counter resets on each accepted RX byte; in HDR/PAYLOAD/DRAIN reaching TIMEOUT_CYCLES -> err_o pulse, IDLE, no response. Not active in EXEC/RESP/ECHO_TX.
- Boundaries: len=0xFFFF legal; byte counter is 16-bit. err_o pulses never overlap; at most one per packet.

Decomposition:
- config_pkg: opcode constants OP_ECHO/OP_ADD/OP_MUL/OP_DIV, HDR_BYTES=4, DIV_ZERO_RESULT=32'hFFFF_FFFF, state enum alu_ctrl_state_e.
- One sub-module: alu_ctrl_resp_ser (32-bit word to 4-byte LE serialiser with valid/ready).

Test Plan:
- Add: AD 00 0C 00 | 01 00 00 00 | 02 00 00 00 -> TX 03 00 00 00, two alu_start_o pulses, err_o never.
- Mul wrap: AC 00 0C 00 | 00 00 01 00 | 00 00 01 00 -> TX 00 00 00 00 (2^32 mod 2^32).
- Div by zero: D1 00 0C 00 | 0A 00 00 00 | 00 00 00 00 -> TX FF FF FF FF, one err_o pulse, zero alu_start_o.
- Echo with TX backpressure: EC 00 07 00 41 42 43, tx_ready_i low 5 cycles per byte -> TX 41 42 43 in order, no loss.
- Unknown opcode: 55 00 06 00 AA BB then AD 00 04 00 -> err_o once, no TX for first; second returns 00 00 00 00.
- Timeout/reset: AD 00 08 00 01 then silence TIMEOUT_CYCLES -> err_o, IDLE, no TX; repeat with rst low mid-payload -> all outputs at reset values, next packet correct.

Source files
------------

// File: rtl/config_pkg.sv
// Shared constants and types for the ALU packet sequencer.
// Opcodes, header size and the FSM state encoding.
package config_pkg;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_MUL  = 8'hAC;
    localparam logic [7:0] OP_DIV  = 8'hD1;

    localparam int HDR_BYTES = 4;

    localparam logic [31:0] DIV_ZERO_RESULT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_EXEC,
        ST_ECHO_TX,
        ST_DRAIN,
        ST_RESP
    } alu_ctrl_state_e;

    function automatic logic is_known_op(input logic [7:0] op);
        return (op == OP_ECHO) || (op == OP_ADD) ||
               (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_ctrl_resp_ser.sv
// Result serialiser: one 32-bit word out as 4 bytes, LSB first.
// A byte is held on tx_data_o until the transmitter takes it.
module alu_ctrl_resp_ser (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] word_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        done_o
);

    logic [31:0] word_q;
    logic [1:0]  idx_q;
    logic        valid_q;

    // Load a word, then step the byte index on each handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            word_q  <= word_i;
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && tx_ready_i) begin
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Present the current byte and flag the final handshake
    always_comb begin
        tx_data_o  = word_q[8*idx_q +: 8];
        tx_valid_o = valid_q;
        done_o     = valid_q && tx_ready_i && (idx_q == 2'd3);
    end

endmodule

// File: rtl/alu_ctrl.sv
// Packet sequencer between the UART byte streams and the ALU.
// Parses command packets, runs the accumulator, returns results.
module alu_ctrl
    import config_pkg::*;
#(
    parameter int ALU_LATENCY    = 1,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [7:0]  alu_opcode_o,
    output logic        alu_start_o,
    output logic [32:0] alu_data1_o,
    output logic [32:0] alu_data2_o,
    input  logic [32:0] alu_data_i,
    output logic        busy_o,
    output logic        err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] LAT = 3'(ALU_LATENCY);

    alu_ctrl_state_e state_q, state_d;

    logic [7:0]    opcode_q;
    logic [1:0]    hdr_cnt_q;
    logic [7:0]    len_lo_q;
    logic [15:0]   rem_q;
    logic [1:0]    byte_idx_q;
    logic [1:0]    word_cnt_q;
    logic [31:0]   word_q;
    logic [31:0]   acc_q;
    logic [7:0]    echo_q;
    logic [2:0]    lat_q;
    logic [TW-1:0] tmo_q;
    logic          err_q;
    logic          err_seen_q;
    logic          alu_start_q;
    logic [7:0]    alu_opcode_q;
    logic [32:0]   alu_data1_q;
    logic [32:0]   alu_data2_q;
    logic          resp_load_q;

    logic          rx_fire;
    logic [31:0]   new_word;
    logic [15:0]   hdr_len;
    logic [15:0]   hdr_pay;
    logic          hdr_end;
    logic          pay_fire;
    logic          last_byte;
    logic          word_done;
    logic          op_arith;
    logic          op_div;
    logic          op_echo;
    logic          op_known;
    logic          div_first;
    logic          div_second;
    logic          div_zero;
    logic          div_short;
    logic          need_exec;
    logic          tmo_act;
    logic          tmo_hit;
    logic          lat_done;
    logic          err_d;

    logic [7:0]    ser_data;
    logic          ser_valid;
    logic          ser_ready;
    logic          ser_done;

    logic          unused_bit32;
    assign unused_bit32 = alu_data_i[32];

    // Decode the current byte and the events it triggers
    always_comb begin
        rx_fire    = rx_valid_i && rx_ready_o;
        new_word   = {rx_data_i, word_q[31:8]};
        hdr_len    = {rx_data_i, len_lo_q};
        hdr_pay    = (hdr_len < 16'(HDR_BYTES)) ? 16'd0
                                                : hdr_len - 16'(HDR_BYTES);
        hdr_end    = rx_fire && (state_q == ST_HDR) && (hdr_cnt_q == 2'd2);
        pay_fire   = rx_fire && (state_q == ST_PAYLOAD);
        last_byte  = (rem_q == 16'd1);
        word_done  = pay_fire && (byte_idx_q == 2'd3);
        op_arith   = (opcode_q == OP_ADD) || (opcode_q == OP_MUL);
        op_div     = (opcode_q == OP_DIV);
        op_echo    = (opcode_q == OP_ECHO);
        op_known   = is_known_op(opcode_q);
        div_first  = word_done && op_div && (word_cnt_q == 2'd0);
        div_second = word_done && op_div && (word_cnt_q == 2'd1);
        div_zero   = div_second && (new_word == 32'd0);
        need_exec  = word_done &&
                     (op_arith || (div_second && new_word != 32'd0));
        div_short  = op_div &&
                     ((hdr_end && hdr_pay == 16'd0) ||
                      (pay_fire && last_byte &&
                       (word_cnt_q == 2'd0 ||
                        (word_cnt_q == 2'd1 && !word_done))));
        tmo_act    = (state_q == ST_HDR) || (state_q == ST_PAYLOAD) ||
                     (state_q == ST_DRAIN);
        tmo_hit    = tmo_act && !rx_fire && (tmo_q == TMO_LAST);
        lat_done   = (state_q == ST_EXEC) && (lat_q == LAT);
        err_d      = !err_seen_q &&
                     ((hdr_end && !op_known) || div_zero ||
                      div_short || tmo_hit);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_fire) state_d = ST_HDR;
            end
            ST_HDR: begin
                if (hdr_end) begin
                    if (!op_known) begin
                        state_d = (hdr_pay == 16'd0) ? ST_IDLE : ST_DRAIN;
                    end else if (hdr_pay == 16'd0) begin
                        state_d = op_echo ? ST_IDLE : ST_RESP;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (pay_fire) begin
                    if (op_echo) state_d = ST_ECHO_TX;
                    else if (need_exec) state_d = ST_EXEC;
                    else if (last_byte) state_d = ST_RESP;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (lat_done) begin
                    state_d = (rem_q == 16'd0) ? ST_RESP : ST_PAYLOAD;
                end
            end
            ST_ECHO_TX: begin
                if (tx_ready_i) begin
                    state_d = (rem_q == 16'd0) ? ST_IDLE : ST_PAYLOAD;
                end
            end
            ST_DRAIN: begin
                if (rx_fire && last_byte) state_d = ST_IDLE;
                else if (tmo_hit) state_d = ST_IDLE;
            end
            ST_RESP: begin
                if (ser_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State-driven outputs and TX source selection
    always_comb begin
        rx_ready_o = (state_q == ST_IDLE) || (state_q == ST_HDR) ||
                     (state_q == ST_PAYLOAD) || (state_q == ST_DRAIN);
        busy_o     = (state_q != ST_IDLE);
        ser_ready  = tx_ready_i && (state_q == ST_RESP);
        if (state_q == ST_ECHO_TX) begin
            tx_valid_o = 1'b1;
            tx_data_o  = echo_q;
        end else begin
            tx_valid_o = ser_valid;
            tx_data_o  = ser_data;
        end
    end

    // Header, payload, accumulator, ALU drive and timeout datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opcode_q     <= '0;
            hdr_cnt_q    <= '0;
            len_lo_q     <= '0;
            rem_q        <= '0;
            byte_idx_q   <= '0;
            word_cnt_q   <= '0;
            word_q       <= '0;
            acc_q        <= '0;
            echo_q       <= '0;
            lat_q        <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
            err_seen_q   <= 1'b0;
            alu_start_q  <= 1'b0;
            alu_opcode_q <= '0;
            alu_data1_q  <= '0;
            alu_data2_q  <= '0;
            resp_load_q  <= 1'b0;
        end else begin
            err_q       <= err_d;
            alu_start_q <= need_exec;
            resp_load_q <= (state_d == ST_RESP) && (state_q != ST_RESP);

            if (state_q == ST_IDLE) err_seen_q <= 1'b0;
            if (err_d) err_seen_q <= 1'b1;

            if (!tmo_act || rx_fire) tmo_q <= '0;
            else tmo_q <= tmo_q + 1'b1;

            if (rx_fire && state_q == ST_IDLE) begin
                opcode_q  <= rx_data_i;
                hdr_cnt_q <= '0;
            end

            if (rx_fire && state_q == ST_HDR) begin
                hdr_cnt_q <= hdr_cnt_q + 2'd1;
                if (hdr_cnt_q == 2'd1) len_lo_q <= rx_data_i;
            end

            if (hdr_end) begin
                rem_q      <= hdr_pay;
                byte_idx_q <= '0;
                word_cnt_q <= '0;
                if (opcode_q == OP_MUL) acc_q <= 32'd1;
                else if (op_div) acc_q <= DIV_ZERO_RESULT;
                else acc_q <= 32'd0;
            end

            if (pay_fire || (rx_fire && state_q == ST_DRAIN)) begin
                rem_q <= rem_q - 16'd1;
            end

            if (pay_fire) begin
                byte_idx_q <= byte_idx_q + 2'd1;
                word_q     <= new_word;
                echo_q     <= rx_data_i;
            end

            if (word_done && word_cnt_q != 2'd2) begin
                word_cnt_q <= word_cnt_q + 2'd1;
            end

            if (need_exec) begin
                alu_data1_q  <= {1'b0, acc_q};
                alu_data2_q  <= {1'b0, new_word};
                alu_opcode_q <= opcode_q;
                lat_q        <= '0;
            end

            if (state_q == ST_EXEC) begin
                lat_q <= lat_q + 3'd1;
                if (lat_done) acc_q <= alu_data_i[31:0];
            end

            if (div_first) acc_q <= new_word;
            if (div_zero || div_short) acc_q <= DIV_ZERO_RESULT;
        end
    end

    assign alu_start_o  = alu_start_q;
    assign alu_opcode_o = alu_opcode_q;
    assign alu_data1_o  = alu_data1_q;
    assign alu_data2_o  = alu_data2_q;
    assign err_o        = err_q;

    alu_ctrl_resp_ser u_ser (
        .clk        (clk),
        .rst        (rst),
        .load_i     (resp_load_q),
        .word_i     (acc_q),
        .tx_data_o  (ser_data),
        .tx_valid_o (ser_valid),
        .tx_ready_i (ser_ready),
        .done_o     (ser_done)
    );

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl: directed packets plus random ones.
// Expected TX bytes come from a word-level model of each command.
module tb_alu_ctrl;
    import config_pkg::*;

    localparam int LAT = 2;
    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data_i = '0;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic [7:0]  alu_opcode_o;
    logic        alu_start_o;
    logic [32:0] alu_data1_o;
    logic [32:0] alu_data2_o;
    logic [32:0] alu_data_i;
    logic        busy_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail = 0;
    int err_cnt = 0;
    int start_cnt = 0;
    int tx_mode = 0;
    bit gaps = 1'b1;
    logic [7:0] cur_op = '0;
    logic [7:0] exp_q[$];
    logic [7:0] pl[$];
    logic [32:0] stg[LAT];

    always #5 clk = ~clk;

    alu_ctrl #(.ALU_LATENCY(LAT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .rx_ready_o   (rx_ready_o),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .alu_opcode_o (alu_opcode_o),
        .alu_start_o  (alu_start_o),
        .alu_data1_o  (alu_data1_o),
        .alu_data2_o  (alu_data2_o),
        .alu_data_i   (alu_data_i),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    function automatic logic [32:0] alu_f(input logic [7:0] op,
                                          input logic [32:0] a,
                                          input logic [32:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_MUL:  return a * b;
            OP_DIV:  return (b == 0) ? 33'd0 : a / b;
            default: return a;
        endcase
    endfunction

    // ALU stand-in: result valid exactly LAT cycles after the start pulse
    always @(posedge clk) begin
        stg[0] <= alu_start_o ? alu_f(alu_opcode_o, alu_data1_o, alu_data2_o)
                              : 33'h1_DEAD_BEEF;
        for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
    end
    assign alu_data_i = stg[LAT-1];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every TX handshake
    always @(negedge clk) begin
        if (rst) begin
            if (err_o) err_cnt++;
            if (alu_start_o) begin
                start_cnt++;
                chk("alu_opcode", 64'(alu_opcode_o), 64'(cur_op));
                chk("alu_bit32", 64'({alu_data1_o[32], alu_data2_o[32]}), 64'd0);
            end
            if (tx_valid_o && tx_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got %02h expected none",
                             tx_data_o);
                end else begin
                    chk("tx_byte", 64'(tx_data_o), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // TX ready: random, or held low 5 cycles per presented byte
    initial forever begin
        int bp;
        @(posedge clk);
        #1;
        if (tx_mode == 0) begin
            tx_ready_i = ($urandom_range(0, 3) != 0);
            bp = 0;
        end else if (!tx_valid_o) begin
            tx_ready_i = 1'b0;
            bp = 0;
        end else if (bp < 5) begin
            tx_ready_i = 1'b0;
            bp++;
        end else begin
            tx_ready_i = 1'b1;
            bp = 0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int g = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!rx_ready_o && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (!rx_ready_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_accept: got ready=0 expected ready=1");
        end
        @(negedge clk);
        rx_valid_i = 1'b0;
        if (gaps && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    task automatic push4(input logic [31:0] v);
        for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
    endtask

    task automatic wait_idle(input int err0, input int st0,
                             input int e_err, input int e_start);
        int g = 0;
        while ((busy_o || exp_q.size() != 0) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        chk("drained", 64'(exp_q.size()), 64'd0);
        chk("idle", 64'(busy_o), 64'd0);
        chk("err_count", 64'(err_cnt - err0), 64'(e_err));
        chk("start_count", 64'(start_cnt - st0), 64'(e_start));
        exp_q.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"},
            64'({rx_ready_o, tx_valid_o, alu_start_o, busy_o, err_o}),
            64'(5'b10000));
        chk({tag, "_op"}, 64'(alu_opcode_o), 64'd0);
        chk({tag, "_d1"}, 64'(alu_data1_o), 64'd0);
        chk({tag, "_d2"}, 64'(alu_data2_o), 64'd0);
    endtask

    // Word-level model of the command, then drive the packet
    task automatic run_packet(input logic [7:0] op, input logic [7:0] rsv,
                              input logic [15:0] len);
        int pay;
        int e_err = 0;
        int e_start = 0;
        int err0;
        int st0;
        logic [31:0] w[$];
        logic [31:0] r;
        pay = (len < 16'd4) ? 0 : int'(len) - 4;
        for (int i = 0; i + 3 < pay; i += 4)
            w.push_back({pl[i+3], pl[i+2], pl[i+1], pl[i]});
        case (op)
            OP_ECHO: foreach (pl[i]) exp_q.push_back(pl[i]);
            OP_ADD: begin
                r = 0;
                foreach (w[i]) r = r + w[i];
                e_start = w.size();
                push4(r);
            end
            OP_MUL: begin
                r = 1;
                foreach (w[i]) r = r * w[i];
                e_start = w.size();
                push4(r);
            end
            OP_DIV: begin
                if (w.size() < 2 || w[1] == 0) begin
                    r = 32'hFFFF_FFFF;
                    e_err = 1;
                end else begin
                    r = w[0] / w[1];
                    e_start = 1;
                end
                push4(r);
            end
            default: e_err = 1;
        endcase
        cur_op = op;
        err0 = err_cnt;
        st0 = start_cnt;
        send_byte(op);
        send_byte(rsv);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        foreach (pl[i]) send_byte(pl[i]);
        wait_idle(err0, st0, e_err, e_start);
    endtask

    initial begin
        int err0;
        int st0;
        logic [7:0] op;
        logic [15:0] len;
        int pay;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;
        @(negedge clk);

        pl = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        run_packet(OP_ADD, 8'h00, 16'd12);
        pl = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
        run_packet(OP_MUL, 8'h00, 16'd12);
        pl = '{8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_packet(OP_DIV, 8'h00, 16'd12);
        pl = '{8'h64, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        run_packet(OP_DIV, 8'h00, 16'd12);
        pl.delete();
        run_packet(OP_DIV, 8'h00, 16'd0);

        tx_mode = 1;
        pl = '{8'h41, 8'h42, 8'h43};
        run_packet(OP_ECHO, 8'h00, 16'd7);
        tx_mode = 0;

        pl = '{8'hAA, 8'hBB};
        run_packet(8'h55, 8'h00, 16'd6);
        pl.delete();
        run_packet(OP_ADD, 8'h00, 16'd4);

        cur_op = OP_ADD;
        err0 = err_cnt;
        st0 = start_cnt;
        send_byte(OP_ADD);
        send_byte(8'h00);
        send_byte(8'h08);
        send_byte(8'h00);
        send_byte(8'h01);
        wait_idle(err0, st0, 1, 0);

        send_byte(OP_ADD);
        send_byte(8'h00);
        send_byte(8'h0C);
        send_byte(8'h00);
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        rst = 1'b0;
        #1;
        chk_reset("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pl = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
        run_packet(OP_ADD, 8'h00, 16'd12);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0, 1: op = OP_ECHO;
                2, 3: op = OP_ADD;
                4, 5: op = OP_MUL;
                6, 7, 8: op = OP_DIV;
                default: begin
                    do op = 8'($urandom); while (is_known_op(op));
                end
            endcase
            if ($urandom_range(0, 7) == 0) len = 16'($urandom_range(0, 3));
            else len = 16'(4 + $urandom_range(0, 14));
            pay = (len < 16'd4) ? 0 : int'(len) - 4;
            pl.delete();
            for (int i = 0; i < pay; i++) pl.push_back(8'($urandom));
            if (op == OP_DIV && pay >= 8 && $urandom_range(0, 2) == 0)
                for (int i = 4; i < 8; i++) pl[i] = 8'h00;
            run_packet(op, 8'($urandom), len);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
